// File: rtl/fetch_queue.sv
// Instruction fetch queue: a fetch-address register drives a combinational
// instruction ROM, and each fetched {pc, instr} pair is buffered in a small
// first-word-fall-through FIFO that decode drains with a valid/ready handshake.
// A redirect from execute flushes the queue and restarts fetch at the target.
module fetch_queue #(
  parameter int              DW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [DW-1:0]   RESET_PC = '0,
  parameter logic [DW-1:0]   PC_INC   = DW'(4)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [DW-1:0]              redirect_pc_i,
  output logic [DW-1:0]              imem_addr_o,
  input  logic [DW-1:0]              imem_data_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [DW-1:0]              instr_o,
  output logic [DW-1:0]              pc_o,
  output logic [DW-1:0]              inc_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Stage p0: fetch address register and the ROM word it selects.
  logic [DW-1:0] fpc_p0;

  // Stage p1: queue storage, pointers and occupancy.
  logic [DW-1:0] pcQ_p1    [DEPTH];
  logic [DW-1:0] instrQ_p1 [DEPTH];
  logic [AW-1:0] headPtr_p1;
  logic [AW-1:0] tailPtr_p1;
  logic [CW-1:0] count_p1;
  logic          vld_p1;

  logic pop;
  logic push;

  assign vld_p1 = (count_p1 != '0);

  // A redirect kills both transfers in its cycle; the refetch starts next cycle.
  // Push is allowed when full only because the simultaneous pop frees a slot.
  assign pop  = !redirect_i && vld_p1 && instr_ready_i;
  assign push = !redirect_i && ((count_p1 < FULL) || pop);

  // Control state: fetch address, pointers and count (reset wins over redirect).
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_p0     <= RESET_PC;
      headPtr_p1 <= '0;
      tailPtr_p1 <= '0;
      count_p1   <= '0;
    end else if (redirect_i) begin
      fpc_p0     <= redirect_pc_i;
      headPtr_p1 <= '0;
      tailPtr_p1 <= '0;
      count_p1   <= '0;
    end else begin
      if (push) begin
        fpc_p0     <= fpc_p0 + PC_INC;
        tailPtr_p1 <= tailPtr_p1 + AW'(1);
      end
      if (pop) begin
        headPtr_p1 <= headPtr_p1 + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + CW'(1);
        2'b01:   count_p1 <= count_p1 - CW'(1);
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // Queue payload: written on push only; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pcQ_p1[tailPtr_p1]    <= fpc_p0;
      instrQ_p1[tailPtr_p1] <= imem_data_i;
    end
  end

  assign imem_addr_o   = fpc_p0;
  assign instr_valid_o = vld_p1;
  assign instr_o       = instrQ_p1[headPtr_p1];
  assign pc_o          = pcQ_p1[headPtr_p1];
  assign inc_pc_o      = pcQ_p1[headPtr_p1] + PC_INC;
  assign count_o       = count_p1;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table on a DEPTH=4 queue, then a
// random-ready ordering run on DEPTH=2 and DEPTH=8 queues.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic rst = 1'b1;

  // DEPTH=4 instance driven by the vector table
  logic        redir4 = 1'b0;
  logic [31:0] rpc4 = '0;
  logic        rdy4 = 1'b0;
  logic [31:0] addr4, data4, instr4, pc4, inc4;
  logic        vld4;
  logic [2:0]  cnt4;
  assign data4 = rom(addr4);

  fetch_queue #(.DW(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .redirect_i(redir4), .redirect_pc_i(rpc4),
    .imem_addr_o(addr4), .imem_data_i(data4), .instr_valid_o(vld4),
    .instr_ready_i(rdy4), .instr_o(instr4), .pc_o(pc4), .inc_pc_o(inc4),
    .count_o(cnt4)
  );

  // DEPTH=2 and DEPTH=8 instances for the random-ready ordering run
  logic        redirX = 1'b0;
  logic [31:0] rpcX = '0;
  logic        rdy2 = 1'b0, rdy8 = 1'b0;
  logic [31:0] addr2, data2, instr2, pc2, inc2;
  logic [31:0] addr8, data8, instr8, pc8, inc8;
  logic        vld2, vld8;
  logic [1:0]  cnt2;
  logic [3:0]  cnt8;
  assign data2 = rom(addr2);
  assign data8 = rom(addr8);

  fetch_queue #(.DW(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .redirect_i(redirX), .redirect_pc_i(rpcX),
    .imem_addr_o(addr2), .imem_data_i(data2), .instr_valid_o(vld2),
    .instr_ready_i(rdy2), .instr_o(instr2), .pc_o(pc2), .inc_pc_o(inc2),
    .count_o(cnt2)
  );

  fetch_queue #(.DW(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .redirect_i(redirX), .redirect_pc_i(rpcX),
    .imem_addr_o(addr8), .imem_data_i(data8), .instr_valid_o(vld8),
    .instr_ready_i(rdy8), .instr_o(instr8), .pc_o(pc8), .inc_pc_o(inc8),
    .count_o(cnt8)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        expValid;
    logic [2:0]  expCount;
    logic [31:0] expAddr;
    logic [31:0] expPc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    int n2, n8;
    logic [31:0] exp2, exp8;

    // rst redir rpc rdy | valid count addr pc
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 3'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd1, 32'h4,         32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd2, 32'h8,         32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd3, 32'hC,         32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd4, 32'h10,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd4, 32'h10,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 32'h14,        32'h4};
    vecs[7]  = '{1'b0, 1'b1, 32'h100,       1'b1, 1'b0, 3'd0, 32'h100,       32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h104,       32'h100};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h108,       32'h104};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h10C,       32'h108};
    vecs[11] = '{1'b1, 1'b1, 32'h200,       1'b1, 1'b0, 3'd0, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h4,         32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h8,         32'h4};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'hC,         32'h8};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd2, 32'h10,        32'h8};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd3, 32'h14,        32'h8};
    vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd4, 32'h18,        32'h8};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd4, 32'h18,        32'h8};
    vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 32'h1C,        32'hC};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 32'h20,        32'h10};
    vecs[21] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 32'h24,        32'h14};
    vecs[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 32'h28,        32'h18};
    vecs[23] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFC, 32'h0};
    vecs[24] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 3'd1, 32'h0,         32'hFFFF_FFFC};
    vecs[25] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 3'd1, 32'h4,         32'h0};
    vecs[26] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 3'd0, 32'h0,         32'h0};

    for (int i = 0; i < NV; i++) begin
      rst    = vecs[i].rst;
      redir4 = vecs[i].redir;
      rpc4   = vecs[i].rpc;
      rdy4   = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), {31'b0, vld4}, {31'b0, vecs[i].expValid});
      check($sformatf("v%0d count", i), {29'b0, cnt4}, {29'b0, vecs[i].expCount});
      check($sformatf("v%0d addr", i), addr4, vecs[i].expAddr);
      if (vecs[i].expValid) begin
        check($sformatf("v%0d pc", i), pc4, vecs[i].expPc);
        check($sformatf("v%0d inc", i), inc4, vecs[i].expPc + 32'd4);
        check($sformatf("v%0d instr", i), instr4, rom(vecs[i].expPc));
      end
    end
    redir4 = 1'b0;
    rdy4   = 1'b0;

    // Random-ready ordering run on DEPTH=2 and DEPTH=8 across pointer wrap
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    exp2 = 32'h0;
    exp8 = 32'h0;
    n2   = 0;
    n8   = 0;
    for (int c = 0; c < 50; c++) begin
      rdy2 = 1'($urandom_range(0, 1));
      rdy8 = 1'($urandom_range(0, 1));
      if (vld2 && rdy2) begin
        check($sformatf("d2 pc #%0d", n2), pc2, exp2);
        check($sformatf("d2 instr #%0d", n2), instr2, rom(exp2));
        exp2 = exp2 + 32'd4;
        n2++;
      end
      if (vld8 && rdy8) begin
        check($sformatf("d8 pc #%0d", n8), pc8, exp8);
        check($sformatf("d8 instr #%0d", n8), instr8, rom(exp8));
        exp8 = exp8 + 32'd4;
        n8++;
      end
      checks++;
      if (cnt2 > 2'd2 || cnt8 > 4'd8) begin
        errors++;
        $display("FAIL occupancy: count2=%0d count8=%0d limits 2/8", cnt2, cnt8);
      end
      @(posedge clk);
      #1;
    end
    rdy2 = 1'b0;
    rdy8 = 1'b0;
    checks++;
    if (n2 < 4 || n8 < 4) begin
      errors++;
      $display("FAIL accept progress: d2=%0d d8=%0d required at least 4 each", n2, n8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
